utemporal_border_ctrl: RTL and testbench

Sequencer for the border input registers of the 8-bit unary-temporal systolic array. It accepts input vectors from upstream over a valid/ready handshake and pulses `load_en` so one column of border registers captures the vector. It then runs a temporal window of 2^(WIDTH-1) cycles, broadcasting the shared temporal count used to compare against each register's magnitude. At the end of a tile it clears the registers and reports completion.

---
 rtl/utemporal_pkg.sv | 19 +
 rtl/utemporal_win_cnt.sv | 25 ++
 rtl/utemporal_border_ctrl.sv | 102 ++++++++++
 tb/tb_utemporal_border_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/utemporal_pkg.sv
// Shared types and helpers for the unary-temporal border register sequencer.
package utemporal_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  // Temporal window length for a signed border register of the given width.
  function automatic int unsigned win_len(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] maxv);
    return (v >= maxv) ? maxv : v + 32'd1;
  endfunction

endpackage

// File: rtl/utemporal_win_cnt.sv
// Window counter: counts 0..WIN-1 while enabled, term flags the final count.
module utemporal_win_cnt
  import utemporal_pkg::*;
#(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         term
);

  localparam int unsigned LAST = win_len(W + 1) - 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  assign term = (cnt == W'(LAST));

endmodule

// File: rtl/utemporal_border_ctrl.sv
// Border register sequencer: vector handshake, temporal window broadcast, tile clear.
module utemporal_border_ctrl
  import utemporal_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int VCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              load_en,
  output logic              reg_clr,
  output logic              run,
  output logic [WIDTH-2:0]  tcnt,
  output logic              win_last,
  output logic              done,
  output logic              busy,
  output logic [VCNT_W-1:0] vec_cnt
);

  localparam int TW = WIDTH - 1;
  localparam logic [31:0] VMAX = 32'((64'd1 << VCNT_W) - 64'd1);

  state_t            state;
  logic              last_q;
  logic [VCNT_W-1:0] vec_q;
  logic [TW-1:0]     tcnt_q;
  logic              term;
  logic              is_idle, is_run, is_clr;
  logic              accept;
  logic [VCNT_W-1:0] vec_inc;

  assign is_idle = (state == ST_IDLE);
  assign is_run  = (state == ST_RUN);
  assign is_clr  = (state == ST_CLEAR);

  assign win_last = is_run & term;
  // flush blocks the handshake so load_en never fires in an abort cycle
  assign in_ready = ~flush & (is_idle | win_last);
  assign accept   = in_valid & in_ready;
  assign load_en  = accept;
  assign reg_clr  = flush | is_clr;
  assign done     = ~flush & (is_clr | (win_last & accept & last_q));
  assign run      = is_run;
  assign busy     = ~is_idle;
  assign tcnt     = tcnt_q;
  assign vec_cnt  = vec_q;
  assign vec_inc  = VCNT_W'(sat_inc(32'(vec_q), VMAX));

  // Counter returns to 0 at every window decision so IDLE always shows tcnt=0.
  utemporal_win_cnt #(.W(TW)) u_win_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush | accept | win_last),
    .en    (is_run),
    .cnt   (tcnt_q),
    .term  (term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      last_q <= 1'b0;
      vec_q  <= '0;
    end else if (flush) begin
      state  <= ST_IDLE;
      last_q <= 1'b0;
      vec_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            last_q <= in_last;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (win_last) begin
            if (accept) begin
              // A last vector followed immediately by a new one starts a new tile.
              last_q <= in_last;
              vec_q  <= last_q ? '0 : vec_inc;
            end else begin
              vec_q <= vec_inc;
              state <= last_q ? ST_CLEAR : ST_IDLE;
            end
          end
        end
        ST_CLEAR: begin
          vec_q  <= '0;
          last_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_utemporal_border_ctrl.sv
// Scoreboard bench: per-phase timeline model predicts every cycle, monitor compares at negedge.
module tb_utemporal_border_ctrl;

  localparam int WIDTH  = 8;
  localparam int VCNT_W = 3;
  localparam int WIN    = 1 << (WIDTH - 1);
  localparam int VMAX   = (1 << VCNT_W) - 1;
  localparam int AB_NONE = 0, AB_FLUSH = 1, AB_RST = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic              in_ready, load_en, reg_clr, run, win_last, done, busy;
  logic [WIDTH-2:0]  tcnt;
  logic [VCNT_W-1:0] vec_cnt;

  utemporal_border_ctrl #(.WIDTH(WIDTH), .VCNT_W(VCNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .load_en(load_en), .reg_clr(reg_clr), .run(run), .tcnt(tcnt),
    .win_last(win_last), .done(done), .busy(busy), .vec_cnt(vec_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit in_ready, load_en, reg_clr, run, win_last, done, busy, tchk;
    int tcnt;
    int vec;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   gcyc  = 0;

  // Vector schedule of the current phase: request cycle, accept cycle, last flag.
  int req_q[$];
  int acc_q[$];
  bit vlast_q[$];
  int trk_d, prev_a;
  bit trk_last;

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp_v);
    end
  endtask

  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("in_ready", e.cyc, 32'(in_ready), 32'(e.in_ready));
        chk("load_en",  e.cyc, 32'(load_en),  32'(e.load_en));
        chk("reg_clr",  e.cyc, 32'(reg_clr),  32'(e.reg_clr));
        chk("run",      e.cyc, 32'(run),      32'(e.run));
        chk("win_last", e.cyc, 32'(win_last), 32'(e.win_last));
        chk("done",     e.cyc, 32'(done),     32'(e.done));
        chk("busy",     e.cyc, 32'(busy),     32'(e.busy));
        chk("vec_cnt",  e.cyc, 32'(vec_cnt),  32'(e.vec));
        if (e.tchk) chk("tcnt", e.cyc, 32'(tcnt), 32'(e.tcnt));
      end
    end
  end

  function automatic exp_t idle_exp();
    exp_t e;
    e.in_ready = 1'b1; e.load_en = 1'b0; e.reg_clr = 1'b0; e.run = 1'b0;
    e.win_last = 1'b0; e.done = 1'b0; e.busy = 1'b0; e.tchk = 1'b0;
    e.tcnt = 0; e.vec = 0; e.cyc = 0;
    return e;
  endfunction

  task automatic new_phase();
    req_q.delete(); acc_q.delete(); vlast_q.delete();
    trk_d = -1; prev_a = -1; trk_last = 1'b0;
  endtask

  // gap counts cycles after the previous accept before in_valid rises.
  task automatic add_vec(input int gap, input bit lst);
    int r, a, base;
    r = (prev_a < 0) ? gap : prev_a + 1 + gap;
    if (trk_d >= 0 && r <= trk_d) a = trk_d;
    else begin
      base = (trk_d < 0) ? 0 : (trk_last ? trk_d + 2 : trk_d + 1);
      a = (r > base) ? r : base;
    end
    req_q.push_back(r); acc_q.push_back(a); vlast_q.push_back(lst);
    trk_d = a + WIN; trk_last = lst; prev_a = a;
  endtask

  task automatic run_phase(input int ab_cyc, input int ab_kind);
    exp_t e[];
    bit   iv[];
    bit   il[];
    int   len, n, k, kn, a, d;
    n   = acc_q.size();
    len = (n > 0) ? acc_q[n-1] + WIN + 4 : 4;
    if (ab_kind != AB_NONE) len = ab_cyc + 4;
    e = new[len]; iv = new[len]; il = new[len];
    for (int c = 0; c < len; c++) begin
      e[c] = idle_exp();
      iv[c] = 1'b0;
      il[c] = 1'($urandom_range(0, 1));
    end
    k = 0;
    for (int i = 0; i < n; i++) begin
      a = acc_q[i]; d = a + WIN;
      for (int c = req_q[i]; c <= a && c < len; c++) begin iv[c] = 1'b1; il[c] = vlast_q[i]; end
      if (a < len) e[a].load_en = 1'b1;
      for (int c = a + 1; c <= d && c < len; c++) begin
        e[c].run = 1'b1; e[c].busy = 1'b1; e[c].tchk = 1'b1; e[c].tcnt = c - a - 1;
        e[c].in_ready = (c == d); e[c].win_last = (c == d); e[c].vec = k;
      end
      kn = (k < VMAX) ? k + 1 : VMAX;
      if (vlast_q[i]) begin
        if (i + 1 < n && acc_q[i+1] == d) begin
          if (d < len) e[d].done = 1'b1;
          for (int c = d + 1; c < len; c++) e[c].vec = 0;
        end else begin
          if (d + 1 < len) begin
            e[d+1].reg_clr = 1'b1; e[d+1].done = 1'b1; e[d+1].busy = 1'b1;
            e[d+1].in_ready = 1'b0; e[d+1].vec = kn;
          end
          for (int c = d + 2; c < len; c++) e[c].vec = 0;
        end
        k = 0;
      end else begin
        for (int c = d + 1; c < len; c++) e[c].vec = kn;
        k = kn;
      end
    end
    if (ab_kind == AB_FLUSH) begin
      e[ab_cyc].reg_clr = 1'b1; e[ab_cyc].load_en = 1'b0;
      e[ab_cyc].in_ready = 1'b0; e[ab_cyc].done = 1'b0;
    end else if (ab_kind == AB_RST) begin
      e[ab_cyc] = idle_exp(); e[ab_cyc].tchk = 1'b1; iv[ab_cyc] = 1'b0;
    end
    if (ab_kind != AB_NONE) begin
      for (int c = ab_cyc + 1; c < len; c++) begin e[c] = idle_exp(); iv[c] = 1'b0; end
      e[ab_cyc+1].tchk = 1'b1;
    end
    for (int c = 0; c < len; c++) begin
      @(posedge clk);
      #1;
      in_valid = iv[c];
      in_last  = il[c];
      flush    = (ab_kind == AB_FLUSH && c == ab_cyc);
      e[c].cyc = gcyc;
      gcyc++;
      sbq.push_back(e[c]);
      if (ab_kind == AB_RST && c == ab_cyc) begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    int nv, sel, gap, ab;
    bit lst;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    new_phase(); run_phase(0, AB_NONE);
    // single vector (0x85 style) ending the tile
    new_phase(); add_vec(2, 1'b1); run_phase(0, AB_NONE);
    // three back-to-back with in_valid held, last on the third
    new_phase(); add_vec(0, 1'b0); add_vec(0, 1'b0); add_vec(0, 1'b1); run_phase(0, AB_NONE);
    // tile end directly followed by a new tile
    new_phase(); add_vec(0, 1'b1); add_vec(0, 1'b1); run_phase(0, AB_NONE);
    // gap: return to IDLE with vec_cnt=1, then a late vector
    new_phase(); add_vec(0, 1'b0); add_vec(WIN + 5, 1'b1); run_phase(0, AB_NONE);
    // in_valid raised at tcnt=10, must wait for win_last
    new_phase(); add_vec(1, 1'b0); add_vec(10, 1'b1); run_phase(0, AB_NONE);
    // flush at tcnt=50
    new_phase(); add_vec(1, 1'b0); add_vec(0, 1'b1); run_phase(acc_q[0] + 51, AB_FLUSH);
    // async reset at tcnt=64, then a fresh accept
    new_phase(); add_vec(1, 1'b1); run_phase(acc_q[0] + 65, AB_RST);
    new_phase(); add_vec(0, 1'b1); run_phase(0, AB_NONE);
    // vec_cnt saturation
    new_phase();
    for (int i = 0; i < 9; i++) add_vec(0, i == 8);
    run_phase(0, AB_NONE);

    for (int p = 0; p < 7; p++) begin
      new_phase();
      nv = $urandom_range(1, 4);
      for (int i = 0; i < nv; i++) begin
        sel = $urandom_range(0, 3);
        case (sel)
          0: gap = $urandom_range(0, WIN - 1);
          1: gap = WIN - 1;
          2: gap = WIN + $urandom_range(0, 3);
          default: gap = WIN + $urandom_range(4, 20);
        endcase
        if (i == 0) gap = $urandom_range(0, 3);
        lst = (i == nv - 1) ? 1'b1 : ($urandom_range(0, 3) == 0);
        add_vec(gap, lst);
      end
      ab = $urandom_range(acc_q[0] + 1, acc_q[nv-1] + WIN);
      if (p == 4)      run_phase(ab, AB_FLUSH);
      else if (p == 5) run_phase(ab, AB_RST);
      else             run_phase(0, AB_NONE);
    end

    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
